// File: rtl/vga_timing_pkg.sv
// Shared raster timing defaults, widths and window helper for the VGA timing stage.
package vga_timing_pkg;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;

    localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned RED_W   = 3;
    localparam int unsigned GREEN_W = 3;
    localparam int unsigned BLUE_W  = 2;
    localparam int unsigned FRAME_W = 8;

    // True when lo <= value < lo+len.
    function automatic logic in_window(input logic [COORD_W-1:0] value,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (32'(value) >= lo) && (32'(value) < (lo + len));
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL raster axis counter; wrap flags the enabled terminal-count cycle.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL = DEF_H_TOTAL,
    parameter int unsigned W     = COORD_W
) (
    input  logic         clk25,
    input  logic         Reset_n,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = enable && (count == W'(TOTAL - 1));

    always_ff @(posedge clk25 or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: counters, frame strobe/count, and the registered sync + blanked colour stage.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic               clk25,
    input  logic               Reset_n,
    input  logic [RED_W-1:0]   red_in,
    input  logic [GREEN_W-1:0] green_in,
    input  logic [BLUE_W-1:0]  blue_in,
    output logic [COORD_W-1:0] xpos,
    output logic [COORD_W-1:0] ypos,
    output logic               visible,
    output logic               end_of_frame,
    output logic [FRAME_W-1:0] frame_count,
    output logic               hsync,
    output logic               vsync,
    output logic [RED_W-1:0]   vga_red,
    output logic [GREEN_W-1:0] vga_green,
    output logic [BLUE_W-1:0]  vga_blue
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Counters are COORD_W bits wide, so neither axis may exceed 1024 positions.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_cfg_err
        $error("vga_timing_gen: H_TOTAL=%0d V_TOTAL=%0d exceeds 1024", H_TOTAL, V_TOTAL);
    end

    logic h_wrap;
    logic v_wrap;

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .W     (COORD_W)
    ) u_h_counter (
        .clk25   (clk25),
        .Reset_n (Reset_n),
        .enable  (1'b1),
        .count   (xpos),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .W     (COORD_W)
    ) u_v_counter (
        .clk25   (clk25),
        .Reset_n (Reset_n),
        .enable  (h_wrap),
        .count   (ypos),
        .wrap    (v_wrap)
    );

    assign visible      = (xpos < COORD_W'(H_VISIBLE)) && (ypos < COORD_W'(V_VISIBLE));
    assign end_of_frame = (xpos == '0) && (ypos == COORD_W'(V_VISIBLE));

    // v_wrap already implies h_wrap, so this fires exactly on the (last,last) cycle.
    always_ff @(posedge clk25 or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_count <= '0;
        end else if (v_wrap) begin
            frame_count <= frame_count + FRAME_W'(1);
        end
    end

    // Single output register keeps syncs and colour aligned; blanking also masks X from the game stage.
    always_ff @(posedge clk25 or negedge Reset_n) begin
        if (!Reset_n) begin
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
            hsync     <= ~SYNC_ACTIVE;
            vsync     <= ~SYNC_ACTIVE;
        end else begin
            vga_red   <= visible ? red_in   : '0;
            vga_green <= visible ? green_in : '0;
            vga_blue  <= visible ? blue_in  : '0;
            hsync     <= in_window(xpos, H_VISIBLE + H_FP, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync     <= in_window(ypos, V_VISIBLE + V_FP, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a small-raster instance for whole-frame behaviour and a default 640x480 instance for line timing.
module tb_vga_timing_gen;

    localparam int unsigned S_HV = 8, S_HFP = 2, S_HS = 3, S_HBP = 2;
    localparam int unsigned S_VV = 6, S_VFP = 1, S_VS = 2, S_VBP = 1;
    localparam int unsigned S_HT = S_HV + S_HFP + S_HS + S_HBP;
    localparam int unsigned S_VT = S_VV + S_VFP + S_VS + S_VBP;

    localparam int unsigned D_HV = 640, D_HFP = 16, D_HS = 96, D_HBP = 48;
    localparam int unsigned D_VV = 480, D_VFP = 10, D_VS = 2, D_VBP = 33;
    localparam int unsigned D_HT = D_HV + D_HFP + D_HS + D_HBP;
    localparam int unsigned D_VT = D_VV + D_VFP + D_VS + D_VBP;

    logic clk25 = 1'b0;
    logic Reset_n;
    always #20 clk25 = ~clk25;

    logic [2:0] red_s, green_s, red_d, green_d;
    logic [1:0] blue_s, blue_d;

    logic [9:0] xpos_s, ypos_s, xpos_d, ypos_d;
    logic       visible_s, eof_s, hsync_s, vsync_s;
    logic       visible_d, eof_d, hsync_d, vsync_d;
    logic [7:0] frame_count_s, frame_count_d;
    logic [2:0] vga_red_s, vga_green_s, vga_red_d, vga_green_d;
    logic [1:0] vga_blue_s, vga_blue_d;

    vga_timing_gen #(
        .H_VISIBLE (S_HV), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
        .V_VISIBLE (S_VV), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
        .SYNC_ACTIVE (1'b0)
    ) dut_s (
        .clk25 (clk25), .Reset_n (Reset_n),
        .red_in (red_s), .green_in (green_s), .blue_in (blue_s),
        .xpos (xpos_s), .ypos (ypos_s), .visible (visible_s),
        .end_of_frame (eof_s), .frame_count (frame_count_s),
        .hsync (hsync_s), .vsync (vsync_s),
        .vga_red (vga_red_s), .vga_green (vga_green_s), .vga_blue (vga_blue_s)
    );

    vga_timing_gen dut_d (
        .clk25 (clk25), .Reset_n (Reset_n),
        .red_in (red_d), .green_in (green_d), .blue_in (blue_d),
        .xpos (xpos_d), .ypos (ypos_d), .visible (visible_d),
        .end_of_frame (eof_d), .frame_count (frame_count_d),
        .hsync (hsync_d), .vsync (vsync_d),
        .vga_red (vga_red_d), .vga_green (vga_green_d), .vga_blue (vga_blue_d)
    );

    // Raster position is a pure function of clocks elapsed since reset release.
    function automatic int unsigned px(input int unsigned k, input int unsigned ht);
        return k % ht;
    endfunction
    function automatic int unsigned py(input int unsigned k, input int unsigned ht, input int unsigned vt);
        return (k / ht) % vt;
    endfunction
    function automatic int unsigned pf(input int unsigned k, input int unsigned ht, input int unsigned vt);
        return (k / (ht * vt)) % 256;
    endfunction
    function automatic logic win(input int unsigned v, input int unsigned lo, input int unsigned len);
        return (v >= lo) && (v < lo + len);
    endfunction

    int unsigned k_s, k_d;
    logic [2:0]  er_s, eg_s, er_d, eg_d;
    logic [1:0]  eb_s, eb_d;
    logic        ehs_s, evs_s, ehs_d, evs_d;

    always @(posedge clk25 or negedge Reset_n) begin
        if (!Reset_n) begin
            k_s <= 0; er_s <= 0; eg_s <= 0; eb_s <= 0; ehs_s <= 1'b1; evs_s <= 1'b1;
            k_d <= 0; er_d <= 0; eg_d <= 0; eb_d <= 0; ehs_d <= 1'b1; evs_d <= 1'b1;
        end else begin
            k_s <= k_s + 1;
            k_d <= k_d + 1;
            if (px(k_s, S_HT) < S_HV && py(k_s, S_HT, S_VT) < S_VV) begin
                er_s <= red_s; eg_s <= green_s; eb_s <= blue_s;
            end else begin
                er_s <= 0; eg_s <= 0; eb_s <= 0;
            end
            if (px(k_d, D_HT) < D_HV && py(k_d, D_HT, D_VT) < D_VV) begin
                er_d <= red_d; eg_d <= green_d; eb_d <= blue_d;
            end else begin
                er_d <= 0; eg_d <= 0; eb_d <= 0;
            end
            ehs_s <= !win(px(k_s, S_HT), S_HV + S_HFP, S_HS);
            evs_s <= !win(py(k_s, S_HT, S_VT), S_VV + S_VFP, S_VS);
            ehs_d <= !win(px(k_d, D_HT), D_HV + D_HFP, D_HS);
            evs_d <= !win(py(k_d, D_HT, D_VT), D_VV + D_VFP, D_VS);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at t=%0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    logic lit_d, lit_s, const_d;
    int   hlow_d, vlow_s, eofcnt_s;

    // Compare process: both instances against the model every cycle, plus pinned literal points.
    always @(negedge clk25) begin
        chk("s.xpos", 32'(xpos_s), px(k_s, S_HT));
        chk("s.ypos", 32'(ypos_s), py(k_s, S_HT, S_VT));
        chk("s.frame_count", 32'(frame_count_s), pf(k_s, S_HT, S_VT));
        chk("s.visible", 32'(visible_s), 32'(px(k_s, S_HT) < S_HV && py(k_s, S_HT, S_VT) < S_VV));
        chk("s.end_of_frame", 32'(eof_s), 32'(px(k_s, S_HT) == 0 && py(k_s, S_HT, S_VT) == S_VV));
        chk("s.hsync", 32'(hsync_s), 32'(ehs_s));
        chk("s.vsync", 32'(vsync_s), 32'(evs_s));
        chk("s.vga_red", 32'(vga_red_s), 32'(er_s));
        chk("s.vga_green", 32'(vga_green_s), 32'(eg_s));
        chk("s.vga_blue", 32'(vga_blue_s), 32'(eb_s));
        chk("d.xpos", 32'(xpos_d), px(k_d, D_HT));
        chk("d.ypos", 32'(ypos_d), py(k_d, D_HT, D_VT));
        chk("d.frame_count", 32'(frame_count_d), pf(k_d, D_HT, D_VT));
        chk("d.visible", 32'(visible_d), 32'(px(k_d, D_HT) < D_HV && py(k_d, D_HT, D_VT) < D_VV));
        chk("d.end_of_frame", 32'(eof_d), 32'(px(k_d, D_HT) == 0 && py(k_d, D_HT, D_VT) == D_VV));
        chk("d.hsync", 32'(hsync_d), 32'(ehs_d));
        chk("d.vsync", 32'(vsync_d), 32'(evs_d));
        chk("d.vga_red", 32'(vga_red_d), 32'(er_d));
        chk("d.vga_green", 32'(vga_green_d), 32'(eg_d));
        chk("d.vga_blue", 32'(vga_blue_d), 32'(eb_d));

        if (lit_d) begin
            if (k_d >= 1 && k_d <= 800 && hsync_d == 1'b0) hlow_d++;
            case (k_d)
                1:   chk("lit.d.first_x", 32'(xpos_d), 1);
                640: begin
                    chk("lit.d.red_after_639", 32'(vga_red_d), 7);
                    chk("lit.d.green_after_639", 32'(vga_green_d), 5);
                    chk("lit.d.blue_after_639", 32'(vga_blue_d), 3);
                end
                641: chk("lit.d.red_after_640", 32'(vga_red_d), 0);
                656: chk("lit.d.hsync_after_655", 32'(hsync_d), 1);
                657: chk("lit.d.hsync_after_656", 32'(hsync_d), 0);
                752: chk("lit.d.hsync_after_751", 32'(hsync_d), 0);
                753: chk("lit.d.hsync_after_752", 32'(hsync_d), 1);
                800: begin
                    chk("lit.d.wrap_x", 32'(xpos_d), 0);
                    chk("lit.d.wrap_y", 32'(ypos_d), 1);
                    chk("lit.d.hsync_low_cycles", 32'(hlow_d), 96);
                end
                default: ;
            endcase
        end

        if (lit_s) begin
            if (eof_s) eofcnt_s++;
            if (k_s >= 1 && k_s <= 150 && vsync_s == 1'b0) vlow_s++;
            case (k_s)
                1:     chk("lit.s.first_x", 32'(xpos_s), 1);
                90: begin
                    chk("lit.s.eof_at_0_6", 32'(eof_s), 1);
                    chk("lit.s.eof_y", 32'(ypos_s), 6);
                end
                150: begin
                    chk("lit.s.vsync_low_cycles", 32'(vlow_s), 30);
                    chk("lit.s.frame1", 32'(frame_count_s), 1);
                    chk("lit.s.frame1_y", 32'(ypos_s), 0);
                end
                38399: chk("lit.s.frame255", 32'(frame_count_s), 255);
                38400: begin
                    chk("lit.s.frame_wrap", 32'(frame_count_s), 0);
                    chk("lit.s.wrap_x", 32'(xpos_s), 0);
                    chk("lit.s.wrap_y", 32'(ypos_s), 0);
                end
                38405: chk("lit.s.eof_pulses", 32'(eofcnt_s), 256);
                default: ;
            endcase
        end
    end

    // Inputs for the cycle whose position is k; X only ever driven on blanked positions.
    task automatic drive();
        if (px(k_s, S_HT) < S_HV && py(k_s, S_HT, S_VT) < S_VV) begin
            red_s = 3'($urandom); green_s = 3'($urandom); blue_s = 2'($urandom);
        end else if ($urandom_range(1) == 1) begin
            red_s = 'x; green_s = 'x; blue_s = 'x;
        end else begin
            red_s = 3'($urandom); green_s = 3'($urandom); blue_s = 2'($urandom);
        end
        if (const_d) begin
            red_d = 3'b111; green_d = 3'b101; blue_d = 2'b11;
        end else if (px(k_d, D_HT) < D_HV && py(k_d, D_HT, D_VT) < D_VV) begin
            red_d = 3'($urandom); green_d = 3'($urandom); blue_d = 2'($urandom);
        end else if ($urandom_range(1) == 1) begin
            red_d = 'x; green_d = 'x; blue_d = 'x;
        end else begin
            red_d = 3'($urandom); green_d = 3'($urandom); blue_d = 2'($urandom);
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        red_s = 0; green_s = 0; blue_s = 0;
        red_d = 0; green_d = 0; blue_d = 0;
        lit_d = 1'b0; lit_s = 1'b0; const_d = 1'b0;
        hlow_d = 0; vlow_s = 0; eofcnt_s = 0;
        repeat (3) @(negedge clk25);
        chk("rst.d.hsync", 32'(hsync_d), 1);
        chk("rst.d.vsync", 32'(vsync_d), 1);
        chk("rst.d.vga_red", 32'(vga_red_d), 0);
        chk("rst.s.frame_count", 32'(frame_count_s), 0);

        // Line timing on the default raster with a constant colour.
        const_d = 1'b1;
        lit_d   = 1'b1;
        Reset_n = 1'b1;
        drive();
        repeat (1100) begin
            @(negedge clk25);
            drive();
        end

        // Asynchronous reset in the middle of a line (default raster at x=300).
        lit_d   = 1'b0;
        const_d = 1'b0;
        #5 Reset_n = 1'b0;
        #1;
        chk("midrst.d.xpos", 32'(xpos_d), 0);
        chk("midrst.d.ypos", 32'(ypos_d), 0);
        chk("midrst.d.hsync", 32'(hsync_d), 1);
        chk("midrst.d.vsync", 32'(vsync_d), 1);
        chk("midrst.d.vga_green", 32'(vga_green_d), 0);
        chk("midrst.s.xpos", 32'(xpos_s), 0);
        chk("midrst.s.vga_blue", 32'(vga_blue_s), 0);
        @(negedge clk25);

        // 256 small-raster frames with random colour.
        lit_s   = 1'b1;
        Reset_n = 1'b1;
        drive();
        repeat (38410) begin
            @(negedge clk25);
            drive();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
